// File: rtl/instruction_fetch_sequencer_pkg.sv
// Shared state encoding, fault codes and defaults for the instruction fetch sequencer.
package fetch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_EXEC,
        ST_HALTED,
        ST_FAULT
    } fetch_state_t;

    typedef logic [1:0] fault_code_t;

    localparam fault_code_t FAULT_NONE       = 2'b00;
    localparam fault_code_t FAULT_MISALIGNED = 2'b01;
    localparam fault_code_t FAULT_TIMEOUT    = 2'b10;

    localparam int DEFAULT_TIMEOUT_CYCLES = 255;

    function automatic logic is_aligned(input logic [1:0] low_bits);
        return low_bits == 2'b00;
    endfunction

endpackage

// File: rtl/instruction_fetch_sequencer_if.sv
// Instruction memory bus: request/address out, single-cycle ready strobe with data back.
interface instruction_fetch_sequencer_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              Mem_Req;
    logic [ADDR_W-1:0] Mem_Addr;
    logic [DATA_W-1:0] Mem_Rdata;
    logic              Mem_Ready;

    modport master (output Mem_Req, output Mem_Addr, input Mem_Rdata, input Mem_Ready);
    modport slave  (input Mem_Req, input Mem_Addr, output Mem_Rdata, output Mem_Ready);
endinterface

// File: rtl/instruction_fetch_sequencer_watchdog.sv
// Fetch watchdog: counts FETCH cycles without a memory response; only built with FETCH_TIMEOUT_EN.
module fetch_watchdog #(
    parameter int LIMIT = 255
) (
    input  logic Clk,
    input  logic Rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);
    localparam int CNT_W = (LIMIT > 255) ? $clog2(LIMIT + 1) : 8;

    logic [CNT_W-1:0] r_count;

    // Expiry is flagged on the LIMIT-th waiting cycle so the FSM leaves FETCH after exactly LIMIT cycles.
    assign o_expired = i_enable && (r_count == CNT_W'(LIMIT - 1));

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && !o_expired) begin
            r_count <= r_count + 1'b1;
        end
    end
endmodule

// File: rtl/instruction_fetch_sequencer.sv
// Fetch sequencer: PC -> memory request -> latched word -> one-cycle cpu_enable commit.
// Optional fetch watchdog is enabled by defining FETCH_TIMEOUT_EN.
module instruction_fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                          Clk,
    input  logic                          Rst,
    input  logic                          Run,
    input  logic                          Halt_Req,
    input  logic [ADDR_W-1:0]             PC_Current,
    instruction_fetch_sequencer_if.master mem,
    output logic [DATA_W-1:0]             Instr,
    output logic [ADDR_W-1:0]             Instr_PC,
    output logic                          cpu_enable,
    output logic                          Halted,
    output logic                          Fault,
    output logic [1:0]                    Fault_Code,
    output logic [31:0]                   Instr_Count
);
    fetch_state_t      r_state;
    fetch_state_t      w_next_state;
    fault_code_t       r_fault_code;
    fault_code_t       w_fault_code;
    logic [DATA_W-1:0] r_instr;
    logic [ADDR_W-1:0] r_instr_pc;
    logic [31:0]       r_instr_count;
    logic              w_aligned;
    logic              w_capture;
    logic              w_timeout;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    assign w_aligned = is_aligned(PC_Current[1:0]);

`ifdef FETCH_TIMEOUT_EN
    fetch_watchdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_watchdog (
        .Clk       (Clk),
        .Rst       (Rst),
        .i_clear   (r_state != ST_FETCH),
        .i_enable  ((r_state == ST_FETCH) && !mem.Mem_Ready),
        .o_expired (w_timeout)
    );
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // The PC may change on the edge that ends EXEC, so alignment is re-checked in FETCH before any request.
    always_comb begin
        w_next_state = r_state;
        w_fault_code = FAULT_NONE;
        w_capture    = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (Run) begin
                    if (w_aligned) begin
                        w_next_state = ST_FETCH;
                    end else begin
                        w_next_state = ST_FAULT;
                        w_fault_code = FAULT_MISALIGNED;
                    end
                end
            end
            ST_FETCH: begin
                if (!w_aligned) begin
                    w_next_state = ST_FAULT;
                    w_fault_code = FAULT_MISALIGNED;
                end else if (mem.Mem_Ready) begin
                    w_next_state = ST_EXEC;
                    w_capture    = 1'b1;
                end else if (w_timeout) begin
                    w_next_state = ST_FAULT;
                    w_fault_code = FAULT_TIMEOUT;
                end
            end
            ST_EXEC: begin
                if (Halt_Req) begin
                    w_next_state = ST_HALTED;
                end else if (Run) begin
                    w_next_state = ST_FETCH;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_HALTED: w_next_state = ST_HALTED;
            ST_FAULT:  w_next_state = ST_FAULT;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    // The count advances at capture so it already includes the instruction committing in EXEC.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_instr       <= '0;
            r_instr_pc    <= '0;
            r_instr_count <= '0;
            r_fault_code  <= FAULT_NONE;
        end else begin
            if (w_capture) begin
                r_instr       <= mem.Mem_Rdata;
                r_instr_pc    <= PC_Current;
                r_instr_count <= r_instr_count + 32'd1;
            end
            if ((w_next_state == ST_FAULT) && (r_state != ST_FAULT)) begin
                r_fault_code <= w_fault_code;
            end
        end
    end

    assign mem.Mem_Req  = (r_state == ST_FETCH) && w_aligned;
    assign mem.Mem_Addr = PC_Current;
    assign Instr        = r_instr;
    assign Instr_PC     = r_instr_pc;
    assign cpu_enable   = (r_state == ST_EXEC);
    assign Halted       = (r_state == ST_HALTED);
    assign Fault        = (r_state == ST_FAULT);
    assign Fault_Code   = r_fault_code;
    assign Instr_Count  = r_instr_count;
endmodule

// File: tb/tb_instruction_fetch_sequencer.sv
// Bench for instruction_fetch_sequencer: random-latency memory and PC model feed a scoreboard
// checked at every cpu_enable. Define FETCH_TIMEOUT_EN to exercise the watchdog path.
module tb_instruction_fetch_sequencer;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 4;

    typedef struct {
        logic [31:0] data;
        logic [31:0] pc;
        logic [31:0] count;
        int          cycle;
    } expect_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic        haltReq;
    logic [31:0] pcCurrent;
    logic [31:0] instr;
    logic [31:0] instrPc;
    logic [31:0] instrCount;
    logic        cpuEnable;
    logic        halted;
    logic        fault;
    logic [1:0]  faultCode;

    expect_t     expQ[$];
    int          checks = 0;
    int          errors = 0;
    int          cycleCount = 0;
    int          retired = 0;
    int          pushCount = 0;
    int          reqSeen = 0;
    int          commitsSeen = 0;
    int          firstCommitCycle = 0;
    int          lastCommitCycle = 0;
    logic [31:0] pcStart = 32'h0;
    logic        memEnable = 1'b1;
    logic        randomLatency = 1'b0;
    int          fixedLatency = 0;
    logic        randomJumps = 1'b0;
    int          haltAt = 0;

    instruction_fetch_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) memBus ();

    instruction_fetch_sequencer #(
        .ADDR_W         (ADDR_W),
        .DATA_W         (DATA_W),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .Clk         (clk),
        .Rst         (rst),
        .Run         (run),
        .Halt_Req    (haltReq),
        .PC_Current  (pcCurrent),
        .mem         (memBus.master),
        .Instr       (instr),
        .Instr_PC    (instrPc),
        .cpu_enable  (cpuEnable),
        .Halted      (halted),
        .Fault       (fault),
        .Fault_Code  (faultCode),
        .Instr_Count (instrCount)
    );

    always #5 clk = ~clk;

    // Memory contents: address 0 holds the reference instruction, everything else a scrambled word.
    function automatic logic [31:0] wordFor(input logic [31:0] addr);
        if (addr == 32'h0) return 32'h00500093;
        return (addr * 32'h9E3779B1) ^ 32'h00000013;
    endfunction

    function automatic logic [31:0] nextPc(input logic [31:0] pc);
        if (randomJumps && ($urandom_range(0, 3) == 0)) return 32'($urandom_range(0, 1023)) << 2;
        return pc + 32'd4;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual 0x%08h, required 0x%08h", name, actual, expected);
        end
    endtask

    task automatic reportTimeout(input string name, input int budget);
        checks++;
        errors++;
        $display("[TB] FAIL %s: condition not reached within %0d cycles", name, budget);
    endtask

    task automatic applyStimulus(input logic runValue);
        @(posedge clk);
        #3;
        run = runValue;
    endtask

    // Reset lands mid-cycle so the outputs can be checked for an immediate, asynchronous clear.
    task automatic applyReset();
        @(posedge clk);
        #3;
        checkOutput("scoreboardDrained", 32'(expQ.size()), 32'd0);
        expQ.delete();
        run = 1'b0;
        rst = 1'b1;
        #1;
        checkOutput("rstMemReq", 32'(memBus.Mem_Req), 32'd0);
        checkOutput("rstCpuEnable", 32'(cpuEnable), 32'd0);
        checkOutput("rstHalted", 32'(halted), 32'd0);
        checkOutput("rstFault", 32'(fault), 32'd0);
        checkOutput("rstFaultCode", 32'(faultCode), 32'd0);
        checkOutput("rstInstr", instr, 32'd0);
        checkOutput("rstInstrPc", instrPc, 32'd0);
        checkOutput("rstInstrCount", instrCount, 32'd0);
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
    endtask

    task automatic waitRetired(input int target, input int budget, input string name);
        int n = 0;
        while (retired < target && n < budget) begin
            @(posedge clk);
            #3;
            n++;
        end
        if (retired < target) reportTimeout(name, budget);
    endtask

    initial begin : cycleCounter
        forever begin
            @(posedge clk);
            cycleCount++;
        end
    end

    // Memory and PC model: advances the PC after each commit and answers requests after a chosen latency.
    initial begin : memoryEnv
        logic wasCommit;
        logic reqActive;
        int   latencyLeft;
        wasCommit = 1'b0;
        reqActive = 1'b0;
        latencyLeft = 0;
        pcCurrent = 32'h0;
        haltReq = 1'b0;
        memBus.Mem_Ready = 1'b0;
        memBus.Mem_Rdata = '0;
        forever begin
            @(negedge clk);
            wasCommit = cpuEnable && !rst;
            if (!rst && memBus.Mem_Req) begin
                reqSeen++;
                checkOutput("memAddr", memBus.Mem_Addr, pcCurrent);
            end
            @(posedge clk);
            #1;
            if (rst) begin
                pcCurrent = pcStart;
                retired = 0;
                pushCount = 0;
                reqActive = 1'b0;
                haltReq = 1'b0;
                memBus.Mem_Ready = 1'b0;
                continue;
            end
            if (wasCommit) pcCurrent = nextPc(pcCurrent);
            #1;
            memBus.Mem_Ready = 1'b0;
            memBus.Mem_Rdata = $urandom;
            haltReq = 1'b0;
            if (cpuEnable) begin
                retired++;
                if (haltAt != 0 && retired == haltAt) haltReq = 1'b1;
            end
            if (memBus.Mem_Req && memEnable) begin
                if (!reqActive) begin
                    reqActive = 1'b1;
                    latencyLeft = randomLatency ? int'($urandom_range(0, 4)) : fixedLatency;
                end
                if (latencyLeft == 0) begin
                    memBus.Mem_Ready = 1'b1;
                    memBus.Mem_Rdata = wordFor(pcCurrent);
                    pushCount++;
                    expQ.push_back('{data: wordFor(pcCurrent), pc: pcCurrent,
                                     count: 32'(pushCount), cycle: cycleCount + 1});
                    reqActive = 1'b0;
                end else begin
                    latencyLeft--;
                end
            end else if (!memBus.Mem_Req) begin
                reqActive = 1'b0;
                if (randomLatency && ($urandom_range(0, 5) == 0)) memBus.Mem_Ready = 1'b1;
            end
        end
    end

    // Scoreboard monitor: every cpu_enable must match the oldest completed fetch.
    initial begin : scoreboardMonitor
        expect_t e;
        logic    prevEnable;
        prevEnable = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prevEnable = 1'b0;
                commitsSeen = 0;
                continue;
            end
            if (cpuEnable) begin
                checkOutput("enableSingleCycle", 32'(prevEnable), 32'd0);
                if (commitsSeen == 0) firstCommitCycle = cycleCount;
                lastCommitCycle = cycleCount;
                commitsSeen++;
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpectedCommit: cpu_enable=1 at cycle %0d, required 0", cycleCount);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("sbInstr", instr, e.data);
                    checkOutput("sbInstrPc", instrPc, e.pc);
                    checkOutput("sbInstrCount", instrCount, e.count);
                    checkOutput("sbCommitCycle", 32'(cycleCount), 32'(e.cycle));
                end
            end
            prevEnable = cpuEnable;
        end
    end

    initial begin : mainSequence
        int reqBefore;
        int n;
        int fetchCycles;
        rst = 1'b1;
        run = 1'b0;
        #2;

        // Single fetch from PC 0 with the memory answering one cycle after the request.
        $display("[TB] single fetch, latency 1");
        pcStart = 32'h0;
        fixedLatency = 1;
        applyReset();
        applyStimulus(1'b1);
        @(posedge clk);
        #3;
        checkOutput("firstMemReq", 32'(memBus.Mem_Req), 32'd1);
        checkOutput("firstMemAddr", memBus.Mem_Addr, 32'h0);
        waitRetired(1, 20, "firstCommit");
        run = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        checkOutput("firstInstr", instr, 32'h00500093);
        checkOutput("firstInstrPc", instrPc, 32'h0);
        checkOutput("firstInstrCount", instrCount, 32'd1);
        checkOutput("firstCommitsSeen", 32'(commitsSeen), 32'd1);

        // Zero-latency memory: ten back-to-back instructions at two cycles each.
        $display("[TB] ten instructions, latency 0");
        pcStart = 32'h100;
        fixedLatency = 0;
        applyReset();
        applyStimulus(1'b1);
        waitRetired(10, 60, "tenCommits");
        run = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        checkOutput("tenInstrCount", instrCount, 32'd10);
        checkOutput("tenSpacing", 32'(lastCommitCycle - firstCommitCycle), 32'd18);
        checkOutput("tenIdleMemReq", 32'(memBus.Mem_Req), 32'd0);

        // Halt request in the third instruction's commit cycle.
        $display("[TB] halt on third instruction");
        pcStart = 32'h200;
        randomLatency = 1'b1;
        haltAt = 3;
        applyReset();
        applyStimulus(1'b1);
        n = 0;
        while (!halted && n < 100) begin
            @(posedge clk);
            #3;
            n++;
        end
        if (!halted) reportTimeout("haltReached", 100);
        reqBefore = reqSeen;
        repeat (10) @(posedge clk);
        #3;
        checkOutput("haltHalted", 32'(halted), 32'd1);
        checkOutput("haltFault", 32'(fault), 32'd0);
        checkOutput("haltInstrCount", instrCount, 32'd3);
        checkOutput("haltRetired", 32'(retired), 32'd3);
        checkOutput("haltNoMoreReq", 32'(reqSeen - reqBefore), 32'd0);
        haltAt = 0;
        randomLatency = 1'b0;

        // Misaligned PC when Run rises: fault next cycle, no request, no commit.
        $display("[TB] misaligned start PC");
        pcStart = 32'h6;
        applyReset();
        reqBefore = reqSeen;
        applyStimulus(1'b1);
        @(posedge clk);
        #1;
        checkOutput("misFault", 32'(fault), 32'd1);
        checkOutput("misFaultCode", 32'(faultCode), 32'd1);
        repeat (6) @(posedge clk);
        #3;
        checkOutput("misNoReq", 32'(reqSeen - reqBefore), 32'd0);
        checkOutput("misFaultSticky", 32'(fault), 32'd1);
        checkOutput("misInstrCount", instrCount, 32'd0);

        // Run dropped while a slow fetch is outstanding: it still commits, then the block idles.
        $display("[TB] run dropped mid-fetch");
        pcStart = 32'h40;
        fixedLatency = 5;
        applyReset();
        applyStimulus(1'b1);
        repeat (3) @(posedge clk);
        #3;
        run = 1'b0;
        repeat (12) @(posedge clk);
        #3;
        checkOutput("dropInstrCount", instrCount, 32'd1);
        checkOutput("dropInstr", instr, wordFor(32'h40));
        checkOutput("dropMemReq", 32'(memBus.Mem_Req), 32'd0);
        checkOutput("dropFault", 32'(fault), 32'd0);
        checkOutput("dropHalted", 32'(halted), 32'd0);

        // Reset while a request is outstanding and the memory never answers.
        $display("[TB] reset mid-fetch");
        pcStart = 32'h80;
        memEnable = 1'b0;
        applyReset();
        applyStimulus(1'b1);
        repeat (3) @(posedge clk);
        #3;
        checkOutput("preResetMemReq", 32'(memBus.Mem_Req), 32'd1);
        applyReset();
        memEnable = 1'b1;

`ifdef FETCH_TIMEOUT_EN
        // Watchdog: no response faults after the limit; a response on the limit cycle wins.
        $display("[TB] fetch watchdog");
        pcStart = 32'h10;
        memEnable = 1'b0;
        applyReset();
        applyStimulus(1'b1);
        fetchCycles = 0;
        n = 0;
        while (!fault && n < 20) begin
            @(negedge clk);
            if (memBus.Mem_Req) fetchCycles++;
            n++;
        end
        if (!fault) reportTimeout("timeoutFault", 20);
        checkOutput("timeoutFetchCycles", 32'(fetchCycles), 32'(TIMEOUT));
        checkOutput("timeoutFaultCode", 32'(faultCode), 32'd2);
        checkOutput("timeoutMemReq", 32'(memBus.Mem_Req), 32'd0);
        memEnable = 1'b1;
        fixedLatency = TIMEOUT - 1;
        applyReset();
        applyStimulus(1'b1);
        waitRetired(1, 20, "limitCycleCommit");
        run = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        checkOutput("limitFault", 32'(fault), 32'd0);
        checkOutput("limitInstrCount", instrCount, 32'd1);
`else
        // Without the watchdog a silent memory leaves the fetch pending indefinitely.
        $display("[TB] no watchdog: fetch waits");
        pcStart = 32'h10;
        memEnable = 1'b0;
        applyReset();
        applyStimulus(1'b1);
        fetchCycles = 0;
        repeat (300) @(posedge clk);
        #3;
        checkOutput("noWdFault", 32'(fault), 32'd0);
        checkOutput("noWdMemReq", 32'(memBus.Mem_Req), 32'd1);
        memEnable = 1'b1;
`endif

        // Randomized runs: random latency, PC jumps, Run toggling and stray ready strobes.
        for (int trial = 0; trial < 4; trial++) begin
            $display("[TB] random trial %0d", trial);
            pcStart = 32'($urandom_range(0, 255)) << 2;
            randomLatency = 1'b1;
            randomJumps = 1'b1;
            applyReset();
            applyStimulus(1'b1);
            n = 0;
            while (retired < 25 && n < 2000) begin
                @(posedge clk);
                #3;
                run = ($urandom_range(0, 7) != 0);
                n++;
            end
            if (retired < 25) reportTimeout("randomCommits", 2000);
            run = 1'b0;
            repeat (12) @(posedge clk);
            #3;
            checkOutput("randInstrCount", instrCount, 32'(retired));
            checkOutput("randMemReq", 32'(memBus.Mem_Req), 32'd0);
            checkOutput("randFault", 32'(fault), 32'd0);
        end
        randomLatency = 1'b0;
        randomJumps = 1'b0;
        applyReset();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
